instr_encoder_loader: RTL and testbench

- Inverse of the instruction field decoder: accepts instruction fields (opcode, Rs, Rt, Rd, shamt, funct, 16-bit constant) over a valid/ready handshake.
- Packs each field set into a 32-bit MIPS-format word.
- Buffers words in a small FIFO and streams them into instruction memory through a write port with backpressure.
- Used by the bench/boot path to load programs into the single-cycle core's instruction memory.

---
 rtl/instr_encoder_loader.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs MIPS R/I-format field sets into 32-bit words and streams them into instruction memory.
// Latency: a field set accepted at edge N is on the write port from cycle N+1, 1 word/cycle.
// Backpressure: mem_ready stalls the FIFO head; in_ready drops only while the FIFO is full.

module instr_encoder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_single
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: reads are qualified by o_empty.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_dat;
    end

    assign o_dat    = r_mem[r_rptr];
    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign o_single = (r_count == ONE_CNT);
endmodule

module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 4,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rtype,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_constant,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic              wrap_err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0] ADDR_INC = (ADDR_W+1)'(WORD_BYTES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_single;
    logic [31:0]       w_enc_word;
    logic [31:0]       w_fifo_head;
    logic [ADDR_W:0]   w_addr_sum;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_word_count;
    logic              r_wrap_err;

    assign w_enc_word = in_rtype ? {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct}
                                 : {in_opcode, in_rs, in_rt, in_constant};

    assign w_push = in_valid && in_ready;
    assign w_pop  = mem_we && mem_ready;

    instr_encoder_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_dat    (w_enc_word),
        .i_pop    (w_pop),
        .o_dat    (w_fifo_head),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty),
        .o_single (w_fifo_single)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Handshake outputs depend on registered state and FIFO count only.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = !w_fifo_full;
                mem_we   = !w_fifo_empty;
                if (in_valid && !w_fifo_full && in_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                mem_we = !w_fifo_empty;
                if (mem_ready && w_fifo_single) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_addr_sum = {1'b0, r_mem_addr} + ADDR_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr   <= '0;
            r_word_count <= '0;
            r_wrap_err   <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_mem_addr   <= base_addr;
            r_word_count <= '0;
            r_wrap_err   <= 1'b0;
        end else if (w_pop) begin
            r_mem_addr <= w_addr_sum[ADDR_W-1:0];
            if (w_addr_sum[ADDR_W]) r_wrap_err <= 1'b1;
            if (r_word_count != '1) r_word_count <= r_word_count + 1'b1;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = w_fifo_empty ? 32'h0 : w_fifo_head;
    assign word_count = r_word_count;
    assign wrap_err   = r_wrap_err;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: fixed encoding table, hand corner-case sequences and
// random sessions, all compared cycle by cycle against a queue-based reference model.

module tb_instr_encoder_loader;
    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 4;
    localparam int WORD_BYTES = 4;
    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_rtype;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_constant;
    logic        in_last;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic [7:0]  word_count;
    logic        wrap_err;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_BYTES(WORD_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_rtype(in_rtype),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_constant(in_constant),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
        .word_count(word_count), .wrap_err(wrap_err)
    );

    typedef struct {
        bit          rtype;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] c;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int          n_chk = 0;
    int          n_fail = 0;
    wr_t         obs_q[$];
    logic [31:0] m_q[$];
    int          m_st, m_addr, m_cnt;
    bit          m_wrap;
    bit          rdy_rand;
    vec_t        tbl[6];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] encode(bit r, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] rd, logic [4:0] sh, logic [5:0] fn,
                                           logic [15:0] c);
        int w;
        w = int'(op) * 67108864 + int'(rs) * 2097152 + int'(rt) * 65536;
        if (r) w = w + int'(rd) * 2048 + int'(sh) * 64 + int'(fn);
        else   w = w + int'(c);
        return 32'(w);
    endfunction

    // Reference model: compare outputs for this cycle, then apply the coming edge.
    task automatic model_tick();
        bit  e_rdy, e_we, push, pop;
        wr_t w;
        if (!rst_n) begin
            m_q.delete();
            m_st = M_IDLE; m_addr = 0; m_cnt = 0; m_wrap = 1'b0;
            chk1("rst_mem_we", mem_we, 1'b0);
            chk1("rst_in_ready", in_ready, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_wrap_err", wrap_err, 1'b0);
            chk("rst_mem_addr", 32'(mem_addr), 32'h0);
            chk("rst_word_count", 32'(word_count), 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            return;
        end
        e_rdy = (m_st == M_LOAD) && (m_q.size() < DEPTH);
        e_we  = (m_st == M_LOAD || m_st == M_DRAIN) && (m_q.size() > 0);
        chk1("in_ready", in_ready, e_rdy);
        chk1("mem_we", mem_we, e_we);
        chk1("busy", busy, m_st != M_IDLE);
        chk1("done", done, m_st == M_DONE);
        chk1("wrap_err", wrap_err, m_wrap);
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("word_count", 32'(word_count), 32'(m_cnt));
        if (e_we) chk("mem_wdata", mem_wdata, m_q[0]);

        push = in_valid && e_rdy;
        pop  = e_we && mem_ready;
        case (m_st)
            M_IDLE:  if (start) begin
                         m_st = M_LOAD; m_addr = int'(base_addr); m_cnt = 0; m_wrap = 1'b0;
                     end
            M_LOAD:  if (push && in_last) m_st = M_DRAIN;
            M_DRAIN: if (pop && m_q.size() == 1) m_st = M_DONE;
            default: m_st = M_IDLE;
        endcase
        if (pop) begin
            w.addr = m_addr;
            w.data = m_q[0];
            obs_q.push_back(w);
            m_q.delete(0);
            if (m_addr + WORD_BYTES > 255) m_wrap = 1'b1;
            m_addr = (m_addr + WORD_BYTES) % 256;
            if (m_cnt < 255) m_cnt++;
        end
        if (push) m_q.push_back(encode(in_rtype, in_opcode, in_rs, in_rt, in_rd,
                                       in_shamt, in_funct, in_constant));
    endtask

    task automatic step();
        @(negedge clk);
        model_tick();
        @(posedge clk);
        #1;
        if (rdy_rand) mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(vec_t v, bit last);
        in_rtype = v.rtype; in_opcode = v.op; in_rs = v.rs; in_rt = v.rt;
        in_rd = v.rd; in_shamt = v.sh; in_funct = v.fn; in_constant = v.c;
        in_last = last; in_valid = 1'b1;
    endtask

    task automatic wait_accept(string name);
        int g = 0;
        while (!in_ready && g < 300) begin step(); g++; end
        chk1({name, "_accept"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send(vec_t v, bit last);
        drive(v, last);
        wait_accept("send");
    endtask

    task automatic start_session(logic [7:0] base);
        base_addr = base;
        start = 1'b1;
        obs_q.delete();
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 2000) begin step(); g++; end
        chk1("done_seen", done, 1'b1);
        step();
    endtask

    task automatic chk_wr(string name, int idx, int addr, logic [31:0] data);
        if (idx < obs_q.size()) begin
            chk({name, "_addr"}, 32'(obs_q[idx].addr), 32'(addr));
            chk({name, "_data"}, obs_q[idx].data, data);
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: write %0d missing, only %0d seen", name, idx, obs_q.size());
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.rtype = 1'($urandom_range(0, 1));
        v.op = 6'($urandom); v.rs = 5'($urandom); v.rt = 5'($urandom);
        v.rd = 5'($urandom); v.sh = 5'($urandom); v.fn = 6'($urandom);
        v.c = 16'($urandom); v.exp = 32'h0;
        return v;
    endfunction

    initial begin
        vec_t  v;
        int    n;
        logic [31:0] held_d;
        logic [7:0]  held_a;

        rst_n = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_rtype = 1'b0;
        in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_funct = '0;
        in_constant = '0; in_last = 1'b0; mem_ready = 1'b0; rdy_rand = 1'b0;
        m_st = M_IDLE; m_addr = 0; m_cnt = 0; m_wrap = 1'b0;

        tbl[0] = '{1'b1, 6'h00, 5'd8,  5'd9, 5'd16, 5'd0,  6'h24, 16'h0000, 32'h01098024};
        tbl[1] = '{1'b1, 6'h00, 5'd8,  5'd9, 5'd18, 5'd0,  6'h22, 16'h0000, 32'h01099022};
        tbl[2] = '{1'b0, 6'h08, 5'd0,  5'd1, 5'd31, 5'd0,  6'h00, 16'h0005, 32'h20010005};
        tbl[3] = '{1'b0, 6'h23, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3f, 16'hfffc, 32'h8fa8fffc};
        tbl[4] = '{1'b1, 6'h00, 5'd0,  5'd9, 5'd8,  5'd4,  6'h00, 16'hbeef, 32'h00094100};
        tbl[5] = '{1'b0, 6'h0f, 5'd0,  5'd5, 5'h15, 5'd3,  6'h2a, 16'h1234, 32'h3c051234};

        #2 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single-word sessions, one per table entry.
        mem_ready = 1'b1;
        foreach (tbl[i]) begin
            start_session(8'h40);
            send(tbl[i], 1'b1);
            wait_done();
            chk($sformatf("tbl%0d_nwr", i), 32'(obs_q.size()), 32'd1);
            chk_wr($sformatf("tbl%0d", i), 0, 8'h40, tbl[i].exp);
            chk($sformatf("tbl%0d_wc", i), 32'(word_count), 32'd1);
        end

        // Mixed R then I stream.
        start_session(8'h10);
        send(tbl[1], 1'b0);
        send(tbl[2], 1'b1);
        wait_done();
        chk_wr("mix0", 0, 8'h10, 32'h01099022);
        chk_wr("mix1", 1, 8'h14, 32'h20010005);
        chk("mix_wc", 32'(word_count), 32'd2);

        // Backpressure: five field sets against a four-entry FIFO.
        mem_ready = 1'b0;
        start_session(8'h20);
        for (int i = 0; i < 4; i++) send(tbl[i], 1'b0);
        chk1("bp_full_rdy", in_ready, 1'b0);
        chk1("bp_we", mem_we, 1'b1);
        held_a = mem_addr;
        held_d = mem_wdata;
        repeat (3) step();
        chk("bp_addr_hold", 32'(mem_addr), 32'(held_a));
        chk("bp_data_hold", mem_wdata, held_d);
        chk("bp_addr", 32'(mem_addr), 32'h20);
        chk("bp_data", mem_wdata, tbl[0].exp);
        drive(tbl[4], 1'b1);
        repeat (2) begin
            step();
            chk1("bp_stall_rdy", in_ready, 1'b0);
        end
        mem_ready = 1'b1;
        wait_accept("bp5");
        wait_done();
        for (int i = 0; i < 5; i++) chk_wr($sformatf("bp%0d", i), i, 8'h20 + 4 * i, tbl[i].exp);
        chk("bp_wc", 32'(word_count), 32'd5);

        // Address wrap and sticky wrap_err.
        start_session(8'hfc);
        send(tbl[0], 1'b0);
        send(tbl[1], 1'b1);
        wait_done();
        chk_wr("wrap0", 0, 8'hfc, tbl[0].exp);
        chk_wr("wrap1", 1, 8'h00, tbl[1].exp);
        chk1("wrap_set", wrap_err, 1'b1);
        repeat (3) step();
        chk1("wrap_sticky", wrap_err, 1'b1);
        start_session(8'h00);
        chk1("wrap_clr", wrap_err, 1'b0);
        send(tbl[2], 1'b1);
        wait_done();
        chk1("wrap_clean", wrap_err, 1'b0);

        // Asynchronous reset in the middle of a stalled session.
        mem_ready = 1'b0;
        start_session(8'h30);
        send(tbl[0], 1'b0);
        send(tbl[1], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk1("arst_we", mem_we, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_rdy", in_ready, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        obs_q.delete();
        repeat (5) step();
        chk("arst_nowr", 32'(obs_q.size()), 32'd0);
        chk1("arst_idle", busy, 1'b0);

        // start pulse during LOAD with another base address.
        start_session(8'h50);
        send(tbl[0], 1'b0);
        start = 1'b1;
        base_addr = 8'h90;
        send(tbl[1], 1'b0);
        start = 1'b0;
        chk1("ign_busy", busy, 1'b1);
        send(tbl[2], 1'b1);
        wait_done();
        chk_wr("ign0", 0, 8'h50, tbl[0].exp);
        chk_wr("ign1", 1, 8'h54, tbl[1].exp);
        chk_wr("ign2", 2, 8'h58, tbl[2].exp);

        // Long session: word_count saturation and wrap from base 0.
        start_session(8'h00);
        for (int i = 0; i < 260; i++) send(tbl[i % 6], i == 259);
        wait_done();
        chk("sat_nwr", 32'(obs_q.size()), 32'd260);
        chk("sat_wc", 32'(word_count), 32'd255);
        chk1("sat_wrap", wrap_err, 1'b1);

        // Random sessions with random ready, gaps and stray start pulses.
        rdy_rand = 1'b1;
        for (int s = 0; s < 40; s++) begin
            start_session(8'($urandom));
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    v = rand_vec();
                    drive(v, 1'($urandom_range(0, 1)));
                    in_valid = 1'b0;
                    step();
                end
                if ($urandom_range(0, 5) == 0) begin
                    start = 1'b1;
                    base_addr = 8'($urandom);
                end
                send(rand_vec(), k == n - 1);
                start = 1'b0;
            end
            wait_done();
            chk($sformatf("rnd%0d_nwr", s), 32'(obs_q.size()), 32'(n));
        end
        rdy_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
